// File: rtl/key_cond_pkg.sv
// Shared types, 50 MHz timing defaults and key indices for the key conditioning stage.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_DELAY,
    REPEATING
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES     = 750000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 12500000;

  localparam int KEY_FUNC = 0;
  localparam int KEY_UP   = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, stable-count debounce and press/repeat/release strobe FSM.
// state      | meaning
// RELEASED   | debounced key up, no strobes pending
// WAIT_DELAY | held, counting toward first auto-repeat (frozen at 0 if repeat disabled)
// REPEATING  | held, strobing key_repeat every rate period
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  logic [DW-1:0] deb_q, deb_d;
  logic          level_q, level_d;
  logic [RW-1:0] rpt_q, rpt_d;
  key_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], key_n_i};
  end

  assign sample = ~sync_q[1];

  always_comb begin
    deb_d   = '0;
    level_d = level_q;
    if (sample != level_q) begin
      if (deb_q == DEB_LAST) level_d = sample;
      else                   deb_d   = deb_q + DW'(1);
    end
  end

  // Edges are taken from level_d so the strobes register together with the level.
  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    if (level_d && !level_q) begin
      state_d  = WAIT_DELAY;
      rpt_d    = '0;
      press_d  = 1'b1;
      repeat_d = 1'b1;
    end else if (!level_d && level_q) begin
      state_d   = RELEASED;
      rpt_d     = '0;
      release_d = 1'b1;
    end else begin
      case (state_q)
        RELEASED: rpt_d = '0;
        WAIT_DELAY: begin
          if (!repeat_en_i) begin
            rpt_d = '0;
          end else if (rpt_q == DELAY_LAST) begin
            rpt_d    = '0;
            repeat_d = 1'b1;
            state_d  = REPEATING;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        REPEATING: begin
          if (rpt_q == RATE_LAST) begin
            rpt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q     <= '0;
      level_q   <= 1'b0;
      rpt_q     <= '0;
      state_q   <= RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      level_q   <= level_d;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw active-low push buttons into synchronous levels and single-cycle strobes
// for the clock/display block; one independent key_channel per key.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int                  NUM_KEYS            = 2,
  parameter int                  DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int                  REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int                  REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK         = NUM_KEYS'(1 << KEY_UP)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_repeat_o
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_bad_params
    $error("key_conditioner: all timing parameters must be >= 2");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .key_n_i    (keys_i[k]),
      .repeat_en_i(REPEAT_MASK[k]),
      .level_o    (key_level_o[k]),
      .press_o    (key_press_o[k]),
      .release_o  (key_release_o[k]),
      .repeat_o   (key_repeat_o[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: behavioural model compared every cycle, plus directed literal timelines.
module tb_key_conditioner;
  import key_cond_pkg::*;

  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 5;
  localparam logic [1:0] MASK = 2'b10;
  localparam logic [63:0] ALL1 = '1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] keys = 2'b11;
  logic [1:0] lvl, prs, rls, rpt;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .keys_i(keys),
    .key_level_o(lvl), .key_press_o(prs), .key_release_o(rls), .key_repeat_o(rpt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: level flips after DEB consecutive differing synced samples; repeats at
  // press age 0, RD, RD+RR, ... while still held (masked keys only at age 0).
  logic [1:0] m_lvl = '0, m_prs = '0, m_rls = '0, m_rpt = '0;
  logic [1:0] h1 = '1, h2 = '1;
  logic       m_s;
  int         run[2];
  int         age[2];

  always @(posedge clk) begin
    if (rst) begin
      h1 = '1; h2 = '1;
      m_lvl = '0; m_prs = '0; m_rls = '0; m_rpt = '0;
      run = '{0, 0}; age = '{0, 0};
    end else begin
      for (int k = 0; k < NK; k++) begin
        m_s = ~h2[k];
        h2[k] = h1[k];
        h1[k] = keys[k];
        m_prs[k] = 1'b0; m_rls[k] = 1'b0; m_rpt[k] = 1'b0;
        if (m_s != m_lvl[k]) run[k]++;
        else                 run[k] = 0;
        if (run[k] == DEB) begin
          run[k] = 0;
          m_lvl[k] = m_s;
          if (m_s) begin
            m_prs[k] = 1'b1; m_rpt[k] = 1'b1; age[k] = 0;
          end else begin
            m_rls[k] = 1'b1;
          end
        end else if (m_lvl[k]) begin
          age[k]++;
          if (MASK[k] && age[k] >= RD && (age[k] - RD) % RR == 0) m_rpt[k] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rst) chk("reset_outputs", {56'd0, lvl, prs, rls, rpt}, 64'd0);
    else     chk("model", {56'd0, lvl, prs, rls, rpt}, {56'd0, m_lvl, m_prs, m_rls, m_rpt});
  end

  // Per-cycle capture of outputs; raw key k after edge c is pattern bit c.
  logic [63:0] v_lvl[2], v_prs[2], v_rls[2], v_rpt[2], v_mrpt[2];

  task automatic rec(input int n, input logic [63:0] p0, input logic [63:0] p1);
    for (int k = 0; k < NK; k++) begin
      v_lvl[k] = '0; v_prs[k] = '0; v_rls[k] = '0; v_rpt[k] = '0; v_mrpt[k] = '0;
    end
    keys = {p1[0], p0[0]};
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NK; k++) begin
        v_lvl[k][c] = lvl[k]; v_prs[k][c] = prs[k];
        v_rls[k][c] = rls[k]; v_rpt[k][c] = rpt[k];
        v_mrpt[k][c] = m_rpt[k];
      end
      keys = {p1[c], p0[c]};
    end
  endtask

  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction

  int hold[2];

  initial begin
    // reset with both keys held
    rst = 1'b1; keys = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", {62'd0, lvl}, 64'd0);
    chk("rst_press", {62'd0, prs}, 64'd0);
    chk("rst_release", {62'd0, rls}, 64'd0);
    chk("rst_repeat", {62'd0, rpt}, 64'd0);
    rst = 1'b0;
    rec(30, ~(b(10) - 1), ~(b(10) - 1));
    chk("por_level0", v_lvl[0], b(16) - b(6));
    chk("por_level1", v_lvl[1], b(16) - b(6));
    chk("por_press0", v_prs[0], b(6));
    chk("por_press1", v_prs[1], b(6));
    chk("por_repeat1", v_rpt[1], b(6));
    chk("por_release1", v_rls[1], b(16));

    // bounce on up key: low 3, high 1, low 3, high
    rec(25, ALL1, ~64'h77);
    chk("bounce_level", v_lvl[1], 64'd0);
    chk("bounce_press", v_prs[1], 64'd0);
    chk("bounce_repeat", v_rpt[1], 64'd0);

    // clean press and hold on up key, raised after edge 28
    rec(45, ALL1, ~(b(28) - 1));
    chk("clean_press", v_prs[1], b(6));
    chk("clean_repeat", v_rpt[1], b(6) | b(16) | b(21) | b(26) | b(31));
    chk("clean_model_repeat", v_mrpt[1], b(6) | b(16) | b(21) | b(26) | b(31));
    chk("clean_release", v_rls[1], b(34));
    chk("clean_level", v_lvl[1], b(34) - b(6));

    // masked function key held 40 cycles
    rec(60, ~(b(40) - 1), ALL1);
    chk("masked_press", v_prs[0], b(6));
    chk("masked_repeat", v_rpt[0], b(6));
    chk("masked_release", v_rls[0], b(46));

    // simultaneous press, function released first
    rec(60, ~(b(20) - 1), ~(b(45) - 1));
    chk("simul_press0", v_prs[0], b(6));
    chk("simul_press1", v_prs[1], b(6));
    chk("simul_release0", v_rls[0], b(26));
    chk("simul_repeat1", v_rpt[1],
        b(6) | b(16) | b(21) | b(26) | b(31) | b(36) | b(41) | b(46));
    chk("simul_release1", v_rls[1], b(51));

    // reset while repeating
    keys = 2'b01;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_level", {62'd0, lvl}, 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_outputs", {56'd0, lvl, prs, rls, rpt}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rec(40, ALL1, ~(b(25) - 1));
    chk("rerst_press", v_prs[1], b(6));
    chk("rerst_repeat", v_rpt[1], b(6) | b(16) | b(21) | b(26));
    chk("rerst_release", v_rls[1], b(31));

    // randomized key activity with occasional resets
    keys = 2'b11;
    hold = '{1, 1};
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
      for (int k = 0; k < NK; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          keys[k] = ~keys[k];
          hold[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                : int'($urandom_range(6, 60));
        end
      end
    end
    keys = 2'b11;
    repeat (20) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
